// File: rtl/rps_referee_if.sv
// Player-side and display-side signals of the rock-paper-scissors referee.
// The master drives start/moves/locks; the slave (referee) drives display and score outputs.
interface rps_referee_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic [2:0]         p1_move;
  logic [2:0]         p2_move;
  logic               p1_lock;
  logic               p2_lock;
  logic [2:0]         disp_code;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               round_done;
  logic               match_over;
  logic               move_err;
  logic               busy;

  modport master (
    output start, p1_move, p2_move, p1_lock, p2_lock,
    input  disp_code, p1_score, p2_score, round_done, match_over, move_err, busy
  );

  modport slave (
    input  start, p1_move, p2_move, p1_lock, p2_lock,
    output disp_code, p1_score, p2_score, round_done, match_over, move_err, busy
  );
endinterface

// File: rtl/rps_referee.sv
// Round sequencer for rock-paper-scissors: collects locks, judges, scores, drives the result code.
// Optional macro RPS_BLINK_EN makes the SHOW / MATCH_END display blink every BLINK_CYCLES cycles.
module rps_referee #(
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int WIN_TARGET     = 3,
  parameter int SCORE_W        = 4,
  parameter int BLINK_CYCLES   = 12_500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  rps_referee_if.slave  bus
);
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_JUDGE     = 3'd2,
    ST_SHOW      = 3'd3,
    ST_MATCH_END = 3'd4
  } state_t;

  localparam logic [2:0] CODE_BLANK = 3'b111;
  localparam logic [2:0] CODE_DASH  = 3'b100;
  localparam logic [2:0] CODE_P1    = 3'b000;
  localparam logic [2:0] CODE_P2    = 3'b001;
  localparam logic [2:0] CODE_DRAW  = 3'b010;
  localparam logic [2:0] ROCK       = 3'b100;
  localparam logic [2:0] PAPER      = 3'b010;
  localparam logic [2:0] SCISSORS   = 3'b001;

  localparam int CNT_MAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [1:0]                lock_in, locked_reg, locked_next, lock_now, acc, err;
  logic [1:0][2:0]           move_in, move_reg;
  logic [1:0][SCORE_W-1:0]   score_reg, score_next;
  logic [2:0]                result_reg, result_next, judge_code, win_code;
  logic [2:0]                disp_reg, disp_next;
  logic                      round_done_reg, move_err_reg, match_over_reg, busy_reg;
  logic                      in_collect, enter_collect, p1_beats, blink_mask;

  assign lock_in       = {bus.p2_lock, bus.p1_lock};
  assign move_in[0]    = bus.p1_move;
  assign move_in[1]    = bus.p2_move;
  assign in_collect    = (state_reg == ST_COLLECT);
  assign enter_collect = (state_next == ST_COLLECT) && !in_collect;

  // Per-player lock acceptance; a locked player's later locks are silently dropped.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic one_hot;
      assign one_hot         = (move_in[gi] == ROCK) || (move_in[gi] == PAPER) ||
                               (move_in[gi] == SCISSORS);
      assign acc[gi]         = in_collect && lock_in[gi] && !locked_reg[gi] && one_hot;
      assign err[gi]         = in_collect && lock_in[gi] && !locked_reg[gi] && !one_hot;
      assign lock_now[gi]    = locked_reg[gi] || acc[gi];
      assign locked_next[gi] = enter_collect ? 1'b0 : lock_now[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (bus.start) state_next = ST_COLLECT;
      ST_COLLECT: begin
        if (&lock_now)              state_next = ST_JUDGE;
        else if (cnt_reg == TMO_LAST) state_next = (|lock_now) ? ST_JUDGE : ST_IDLE;
      end
      ST_JUDGE:     state_next = ST_SHOW;
      ST_SHOW: begin
        if (cnt_reg == SHOW_LAST)
          state_next = (score_reg[0] == TARGET || score_reg[1] == TARGET) ? ST_MATCH_END
                                                                          : ST_COLLECT;
      end
      ST_MATCH_END: if (bus.start) state_next = ST_COLLECT;
      default:      state_next = ST_IDLE;
    endcase
  end

  // A lone locked player wins by forfeit; otherwise the usual cyclic rules apply.
  always_comb begin
    p1_beats = (move_reg[0] == ROCK     && move_reg[1] == SCISSORS) ||
               (move_reg[0] == SCISSORS && move_reg[1] == PAPER)    ||
               (move_reg[0] == PAPER    && move_reg[1] == ROCK);
    if (&locked_reg)
      judge_code = (move_reg[0] == move_reg[1]) ? CODE_DRAW : (p1_beats ? CODE_P1 : CODE_P2);
    else
      judge_code = locked_reg[0] ? CODE_P1 : CODE_P2;
  end

`ifdef RPS_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic               blink_off_reg, blink_off_next;

  always_comb begin
    blink_cnt_next = blink_cnt_reg + 1'b1;
    blink_off_next = blink_off_reg;
    if (state_next != state_reg) begin
      blink_cnt_next = '0;
      blink_off_next = 1'b0;
    end else if (blink_cnt_reg == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_next = '0;
      blink_off_next = !blink_off_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
    end else begin
      blink_cnt_reg <= blink_cnt_next;
      blink_off_reg <= blink_off_next;
    end
  end

  assign blink_mask = blink_off_next && (state_next == ST_SHOW || state_next == ST_MATCH_END);
`else
  // The blink period only matters when blinking is built in.
  logic [31:0] unused_blink_cycles;
  assign unused_blink_cycles = 32'(BLINK_CYCLES);
  assign blink_mask          = 1'b0;
`endif

  always_comb begin
    cnt_next    = (state_next != state_reg) ? '0 : cnt_reg + 1'b1;
    result_next = (state_reg == ST_JUDGE) ? judge_code : result_reg;
    score_next  = score_reg;
    if (state_reg == ST_JUDGE) begin
      if (judge_code == CODE_P1 && score_reg[0] < TARGET) score_next[0] = score_reg[0] + 1'b1;
      if (judge_code == CODE_P2 && score_reg[1] < TARGET) score_next[1] = score_reg[1] + 1'b1;
    end else if (state_reg == ST_MATCH_END && state_next == ST_COLLECT) begin
      score_next = '0;
    end
    win_code = (score_next[0] == TARGET) ? CODE_P1 : CODE_P2;
    case (state_next)
      ST_COLLECT, ST_JUDGE: disp_next = CODE_DASH;
      ST_SHOW:              disp_next = result_next;
      ST_MATCH_END:         disp_next = win_code;
      default:              disp_next = CODE_BLANK;
    endcase
    if (blink_mask) disp_next = CODE_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      locked_reg     <= '0;
      move_reg       <= '0;
      score_reg      <= '0;
      result_reg     <= CODE_DRAW;
      disp_reg       <= CODE_BLANK;
      round_done_reg <= 1'b0;
      move_err_reg   <= 1'b0;
      match_over_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      locked_reg     <= locked_next;
      for (int i = 0; i < 2; i++)
        if (acc[i]) move_reg[i] <= move_in[i];
      score_reg      <= score_next;
      result_reg     <= result_next;
      disp_reg       <= disp_next;
      round_done_reg <= (state_reg == ST_JUDGE);
      move_err_reg   <= |err;
      match_over_reg <= (state_next == ST_MATCH_END);
      busy_reg       <= (state_next == ST_COLLECT) || (state_next == ST_JUDGE) ||
                        (state_next == ST_SHOW);
    end
  end

  assign bus.disp_code  = disp_reg;
  assign bus.p1_score   = score_reg[0];
  assign bus.p2_score   = score_reg[1];
  assign bus.round_done = round_done_reg;
  assign bus.move_err   = move_err_reg;
  assign bus.match_over = match_over_reg;
  assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_rps_referee.sv
// Randomised bench for rps_referee against a round-level model of the game rules.
// Define RPS_BLINK_EN for both bench and RTL to check the blinking display.
module tb_rps_referee;
  localparam int SHOW_CYCLES    = 4;
  localparam int TIMEOUT_CYCLES = 10;
  localparam int WIN_TARGET     = 2;
  localparam int SCORE_W        = 4;
  localparam int BLINK_CYCLES   = 2;
  localparam int W_IDLE = 0, W_COLLECT = 1, W_END = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   s1 = 0, s2 = 0;
  int   where = W_IDLE;
  int   round_no = 0;
  logic [2:0] bad_moves [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  rps_referee_if #(.SCORE_W(SCORE_W)) bus ();

  rps_referee #(
    .SHOW_CYCLES(SHOW_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .WIN_TARGET(WIN_TARGET),
    .SCORE_W(SCORE_W), .BLINK_CYCLES(BLINK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (round %0d): got %0h expected %0h", tag, round_no, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.p1_lock = 1'b0; bus.p2_lock = 1'b0;
  endtask

  function automatic logic [2:0] onehot_of(input int idx);
    return 3'(4 >> idx);  // 0 rock, 1 paper, 2 scissors
  endfunction

  // Paper beats rock, scissors beats paper, rock beats scissors: a beats b when (a-b) mod 3 == 1.
  function automatic logic [2:0] referee(input int a, input int b);
    if (a == b) return 3'b010;
    return (((a - b + 3) % 3) == 1) ? 3'b000 : 3'b001;
  endfunction

  function automatic logic [2:0] shown(input logic [2:0] code, input int off);
`ifdef RPS_BLINK_EN
    return (((off / BLINK_CYCLES) % 2) == 1) ? 3'b111 : code;
`else
    return (off >= 0) ? code : 3'b111;
`endif
  endfunction

  task automatic check_scores(input string tag);
    check_eq({tag, "_p1_score"}, 32'(bus.p1_score), 32'(s1));
    check_eq({tag, "_p2_score"}, 32'(bus.p2_score), 32'(s2));
  endtask

  task automatic enter_collect();
    logic [2:0] win;
    if (where == W_IDLE) begin
      bus.p2_lock = 1'b1; bus.p2_move = 3'b110;
      tick(); clear_inputs();
      check_eq("idle_lock_err", 32'(bus.move_err), 0);
      check_eq("idle_disp", 32'(bus.disp_code), 32'(3'b111));
      bus.start = 1'b1;
      tick(); clear_inputs();
    end else if (where == W_END) begin
      win = (s1 == WIN_TARGET) ? 3'b000 : 3'b001;
      for (int off = 1; off <= 2; off++) begin
        bus.p1_lock = 1'b1; bus.p1_move = 3'b011;
        tick(); clear_inputs();
        check_eq("end_lock_err", 32'(bus.move_err), 0);
        check_eq("end_disp", 32'(bus.disp_code), 32'(shown(win, off)));
        check_eq("end_match_over", 32'(bus.match_over), 1);
        check_scores("end");
      end
      bus.start = 1'b1;
      tick(); clear_inputs();
      s1 = 0; s2 = 0;
      check_scores("new_match");
    end
    check_eq("collect_disp", 32'(bus.disp_code), 32'(3'b100));
    check_eq("collect_busy", 32'(bus.busy), 1);
    check_eq("collect_match_over", 32'(bus.match_over), 0);
    where = W_COLLECT;
  endtask

  // g1/g2: COLLECT cycle index at which each player locks, -1 for never.
  task automatic run_round(input int a, input int b, input int g1, input int g2,
                           input bit bad1, input bit rand_start);
    bit both, any;
    int last, bad_k, r1, r2;
    logic [2:0] code, win;
    round_no++;
    both  = (g1 >= 0) && (g2 >= 0);
    any   = (g1 >= 0) || (g2 >= 0);
    last  = both ? ((g1 > g2) ? g1 : g2) : TIMEOUT_CYCLES - 1;
    bad_k = (bad1 && g1 >= 1) ? g1 - 1 : -1;
    r1 = -1; r2 = -1;
    if (g1 >= 0 && g1 < last) r1 = $urandom_range(g1 + 1, last);
    if (g2 >= 0 && g2 < last) r2 = $urandom_range(g2 + 1, last);
    if (both && r1 == last) r1 = -1;
    if (both && r2 == last) r2 = -1;
    for (int k = 0; k <= last; k++) begin
      bus.start   = rand_start && ($urandom_range(0, 2) == 0);
      bus.p1_lock = (k == g1) || (k == bad_k) || (k == r1);
      bus.p1_move = (k == g1) ? onehot_of(a) : (k == bad_k) ? bad_moves[$urandom_range(0, 4)]
                                                            : 3'($urandom_range(0, 7));
      bus.p2_lock = (k == g2) || (k == r2);
      bus.p2_move = (k == g2) ? onehot_of(b) : 3'($urandom_range(0, 7));
      tick(); clear_inputs();
      check_eq("move_err", 32'(bus.move_err), 32'(k == bad_k));
      if (k < last) begin
        check_eq("collect_hold_disp", 32'(bus.disp_code), 32'(3'b100));
        check_eq("collect_hold_busy", 32'(bus.busy), 1);
      end
    end
    if (!any) begin
      check_eq("abandon_disp", 32'(bus.disp_code), 32'(3'b111));
      check_eq("abandon_busy", 32'(bus.busy), 0);
      check_eq("abandon_round_done", 32'(bus.round_done), 0);
      check_scores("abandon");
      where = W_IDLE;
      $display("round %0d: no locks, abandoned to idle", round_no);
      return;
    end
    check_eq("judge_disp", 32'(bus.disp_code), 32'(3'b100));
    check_eq("judge_busy", 32'(bus.busy), 1);
    check_eq("judge_round_done", 32'(bus.round_done), 0);
    code = both ? referee(a, b) : ((g1 >= 0) ? 3'b000 : 3'b001);
    if (code == 3'b000 && s1 < WIN_TARGET) s1++;
    if (code == 3'b001 && s2 < WIN_TARGET) s2++;
    bus.start = rand_start;
    tick(); clear_inputs();
    check_eq("show_disp", 32'(bus.disp_code), 32'(shown(code, 0)));
    check_eq("show_round_done", 32'(bus.round_done), 1);
    check_scores("show");
    for (int off = 1; off < SHOW_CYCLES; off++) begin
      bus.start = rand_start && ($urandom_range(0, 1) == 0);
      tick(); clear_inputs();
      check_eq("show_hold_disp", 32'(bus.disp_code), 32'(shown(code, off)));
      check_eq("show_hold_round_done", 32'(bus.round_done), 0);
    end
    tick();
    if (s1 == WIN_TARGET || s2 == WIN_TARGET) begin
      win = (s1 == WIN_TARGET) ? 3'b000 : 3'b001;
      check_eq("match_end_disp", 32'(bus.disp_code), 32'(shown(win, 0)));
      check_eq("match_end_over", 32'(bus.match_over), 1);
      check_eq("match_end_busy", 32'(bus.busy), 0);
      where = W_END;
    end else begin
      check_eq("next_collect_disp", 32'(bus.disp_code), 32'(3'b100));
      check_eq("next_collect_busy", 32'(bus.busy), 1);
      where = W_COLLECT;
    end
    $display("round %0d: p1 %0d@%0d p2 %0d@%0d -> code %b, score %0d-%0d",
             round_no, a, g1, b, g2, code, s1, s2);
  endtask

  initial begin
    int a, b, g1, g2;
    bus.start = 1'b0; bus.p1_lock = 1'b0; bus.p2_lock = 1'b0;
    bus.p1_move = 3'b000; bus.p2_move = 3'b000;
    repeat (3) tick();
    check_eq("reset_disp", 32'(bus.disp_code), 32'(3'b111));
    check_scores("reset");
    check_eq("reset_busy", 32'(bus.busy), 0);
    check_eq("reset_match_over", 32'(bus.match_over), 0);
    check_eq("reset_round_done", 32'(bus.round_done), 0);
    check_eq("reset_move_err", 32'(bus.move_err), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_disp_after_reset", 32'(bus.disp_code), 32'(3'b111));

    enter_collect();
    run_round(0, 2, 0, 0, 1'b0, 1'b0);   // rock beats scissors, same-cycle locks
    run_round(1, 1, 2, 5, 1'b0, 1'b1);   // paper draw
    run_round(2, 1, 3, 1, 1'b1, 1'b0);   // bad lock first, scissors beats paper; match ends
    enter_collect();
    run_round(0, 0, -1, 0, 1'b0, 1'b0);  // p2 forfeit win
    run_round(0, 0, -1, -1, 1'b0, 1'b0); // abandon
    enter_collect();
    run_round(1, 0, 9, 4, 1'b0, 1'b0);   // second lock on the timeout cycle

    for (int r = 0; r < 30; r++) begin
      if (where != W_COLLECT) enter_collect();
      a  = $urandom_range(0, 2);
      b  = $urandom_range(0, 2);
      g1 = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TIMEOUT_CYCLES - 1);
      g2 = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TIMEOUT_CYCLES - 1);
      run_round(a, b, g1, g2, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of SHOW.
    if (where != W_COLLECT) enter_collect();
    bus.p1_lock = 1'b1; bus.p1_move = 3'b010;
    bus.p2_lock = 1'b1; bus.p2_move = 3'b100;
    tick(); clear_inputs();
    tick();
    check_eq("pre_reset_round_done", 32'(bus.round_done), 1);
    #2 rst_n = 1'b0;
    #1;
    s1 = 0; s2 = 0;
    check_eq("async_reset_disp", 32'(bus.disp_code), 32'(3'b111));
    check_scores("async_reset");
    check_eq("async_reset_busy", 32'(bus.busy), 0);
    check_eq("async_reset_round_done", 32'(bus.round_done), 0);
    #2 rst_n = 1'b1;
    tick();
    check_eq("post_reset_idle_disp", 32'(bus.disp_code), 32'(3'b111));
    check_eq("post_reset_busy", 32'(bus.busy), 0);
    $display("round %0d: reset during SHOW returned to idle", round_no);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rps_referee.md
# rps_referee

Round sequencer for the rock-paper-scissors game. It accepts locked-in moves from two players, judges each round, and keeps match scores. It drives the 3-bit result code of the shared 7-segment decoder: blank, dash, "1", "2", or "d" for draw. It sits between the player input synchronisers/debouncers and the display decoder, and owns all game state.

## Interface
- SHOW_CYCLES, 50_000_000: cycles a round result is held before the next round (≥2)
- TIMEOUT_CYCLES, 250_000_000: cycles allowed in COLLECT before forfeit/abandon (≥2)
- WIN_TARGET, 3: round wins needed to take the match (1..2^SCORE_W-1)
- SCORE_W, 4: score counter width
- BLINK_CYCLES, 12_500_000: blink half-period; used only with RPS_BLINK_EN
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin round (IDLE) or new match (MATCH_END)
- p1_move, p2_move  in  3  one-hot move: 100 rock, 010 paper, 001 scissors
- p1_lock, p2_lock  in  1  one-cycle pulse: lock the current move
- disp_code  out  3  to decoder: 111 blank, 100 dash, 000 "1", 001 "2", 010 "d"
- p1_score, p2_score  out  SCORE_W  round wins this match
- round_done  out  1  one-cycle pulse when a round result is scored
- match_over  out  1  high while in MATCH_END
- move_err  out  1  one-cycle pulse on a rejected lock
- busy  out  1  high in COLLECT, JUDGE, SHOW

## Operation
- States:
  - IDLE: disp 111. start → COLLECT.
  - COLLECT: disp 100. Gathers the locks from both players.
  - JUDGE: 1 cycle. Computes the result.
  - SHOW: disp shows the result for SHOW_CYCLES cycles.
  - MATCH_END: disp shows the match winner; start → clear scores → COLLECT.
- Lock acceptance, in COLLECT only:
  - A lock is accepted if the move is exactly one-hot and that player is not yet locked. The move is captured.
  - A lock with a non-one-hot move is rejected: move_err pulses and the player stays unlocked.
  - A repeat lock from an already-locked player is ignored silently.
  - Both players may lock in the same cycle; both locks are accepted.
  - Locks in any other state are ignored, with no move_err.
- COLLECT → JUDGE in the cycle after both players are locked.
- Judge rules: rock beats scissors, scissors beats paper, paper beats rock. Equal moves are a draw, code 010. P1 win is 000; P2 win is 001.
- Timeout: the counter is cleared on entry to COLLECT.
  - If it reaches TIMEOUT_CYCLES with exactly one player locked, that player wins by forfeit through JUDGE/SHOW.
  - If no player is locked, go to IDLE with no score change and no round_done.
  - Reaching the timeout in the same cycle as the second lock counts as a normal completion.
- Scoring on the JUDGE → SHOW edge:
  - The winner's score increments; a draw changes nothing.
  - round_done pulses in the first SHOW cycle.
  - Scores never exceed WIN_TARGET.
- SHOW exit: if either score equals WIN_TARGET, go to MATCH_END with disp 000 or 001 for the winner. Otherwise go to COLLECT with both locks cleared.
- start is ignored in COLLECT, JUDGE and SHOW.
- Reset, from any state including mid-round: state IDLE, disp_code 111, scores 0, locks cleared, all pulses 0, match_over 0, busy 0.

## Timing
- All outputs are registered and change on the clock edge after the triggering input.
- start in IDLE at edge N gives COLLECT and disp 100 from N+1.
- Last lock at edge N gives JUDGE at N+1, then SHOW, the result, the score update and round_done at N+2.
- SHOW lasts exactly SHOW_CYCLES cycles. The next state is entered at SHOW entry + SHOW_CYCLES.
- A timeout occurs TIMEOUT_CYCLES cycles after COLLECT entry.
- move_err is asserted the cycle after the offending lock.

## Configuration
- RPS_BLINK_EN defined:
  - In SHOW and MATCH_END, disp_code alternates between the result code and 111 every BLINK_CYCLES cycles.
  - It starts on the result code at state entry, and the blink phase restarts on each entry.
- RPS_BLINK_EN undefined: the result is held steady, and the BLINK_CYCLES counter logic is not built.

## Test plan
Bench parameters: SHOW_CYCLES=4, TIMEOUT_CYCLES=10, WIN_TARGET=2, macro undefined unless stated.
- Reset, then start. Then p1 rock and p2 scissors locked in the same cycle. Expect JUDGE, then disp 000, p1_score 1 and round_done for 1 cycle, then disp 100 after 4 cycles.
- p1 paper and p2 paper. Expect disp 010, scores unchanged, round_done pulse.
- p1 locks 011. Expect move_err pulse and no lock. Then p1 relocks 001 and p2 locks 010. Expect p1 win (scissors beats paper).
- Only p2 locks rock; wait 10 cycles. Expect forfeit: disp 001, p2_score +1. Separately, with no locks, expect IDLE and disp 111 after 10 cycles.
- P1 wins 2 rounds. Expect MATCH_END, match_over=1, disp 000 held. start then clears scores to 0 and gives disp 100.
- rst_n low mid-SHOW. Expect immediate IDLE, disp 111, scores 0. With RPS_BLINK_EN and BLINK_CYCLES=2, expect the SHOW disp sequence 000,000,111,111.
